// File: rtl/dsp_xintf_bank_bridge_pkg.sv
// Shared types and helpers for the XINTF bank bridge.
// FSM encoding is fixed so that o_state reads the same in every build.
package dsp_xintf_pkg;

    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        WR_SETTLE = 3'd2,
        COMMIT    = 3'd3,
        HOLD      = 3'd4
    } xintf_state_t;

    // Returns the bit width needed to hold indices 0..value-1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 0;
        while ((64'd1 << w) < 64'(value)) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/dsp_xintf_bank_bridge_sync.sv
// Multi-flop synchroniser for an active-low asynchronous strobe.
// Resets to 1, which is the inactive level of the strobe.
module xintf_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/dsp_xintf_bank_bridge.sv
// DSP XINTF to multi-bank dual-port BRAM bridge with a waveform read RAM.
// Writes are synchronised, settled and committed once per strobe; reads are held and driven back.
module dsp_xintf_bank_bridge
    import dsp_xintf_pkg::*;
#(
    parameter int unsigned RAM_AW      = 9,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned BANK_N      = 4,
    parameter int unsigned XA_W        = 11,
    parameter int unsigned SETTLE      = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_wf_en,
    input  logic                       i_nZ_B_CS,
    input  logic                       i_nZ_B_WE,
    input  logic [XA_W-1:0]            i_Z_B_XA,
    inout  logic [DATA_W-1:0]          io_Z_B_XD,
    output logic [RAM_AW-1:0]          o_w_ram_addr,
    output logic [BANK_N-1:0]          o_w_ram_ce,
    output logic [BANK_N-1:0]          o_w_ram_we,
    output logic [DATA_W-1:0]          o_w_ram_din,
    output logic [RAM_AW-1:0]          o_r_ram_addr,
    output logic [BANK_N-1:0]          o_r_ram_ce,
    input  logic [BANK_N*DATA_W-1:0]   i_r_ram_dout,
    output logic [RAM_AW-1:0]          o_wf_ram_addr,
    output logic                       o_wf_ram_ce,
    input  logic [DATA_W-1:0]          i_wf_ram_dout,
    output logic                       o_wr_done,
    output logic                       o_wr_abort,
    output logic                       o_bank_err,
    output logic [15:0]                o_wr_cnt,
    output logic [2:0]                 o_state
);

    localparam int unsigned BANK_W = XA_W - RAM_AW;
    localparam int unsigned CNT_W  = clog2(SETTLE + 1);

    logic w_cs_s;
    logic w_we_s;
    logic w_wr_act;
    logic w_rd_act;
    logic w_primed;
    logic w_rd_pin;

    xintf_state_t r_state;
    xintf_state_t w_state_nx;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nx;
    logic                   w_latch;
    logic                   w_abort;
    logic [SYNC_STAGES-1:0] r_prime;
    logic [XA_W-1:0]        r_xa_lat;
    logic [DATA_W-1:0]      r_xd_lat;
    logic [15:0]            r_wr_cnt;
    logic                   r_rd_prev;
    logic [DATA_W-1:0]      r_hold;

    logic [BANK_W-1:0] w_wbank;
    logic [BANK_W-1:0] w_rbank;
    logic              w_wbank_ok;
    logic              w_rbank_ok;
    logic              w_commit;
    logic              w_commit_ok;
    logic              w_commit_err;
    logic              w_rd_err;
    logic [DATA_W-1:0] w_bank_dout;
    logic [DATA_W-1:0] w_rd_data;

    xintf_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_nZ_B_CS),
        .o_q   (w_cs_s)
    );

    xintf_sync #(.STAGES(SYNC_STAGES)) u_sync_we (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_nZ_B_WE),
        .o_q   (w_we_s)
    );

    assign w_wr_act = ~w_cs_s & ~w_we_s;
    assign w_rd_act = ~w_cs_s &  w_we_s;
    // The synchronisers reset to the idle level, so their output only reflects
    // the pins once they have been refilled; WAIT_IDLE ignores them until then.
    assign w_primed = r_prime[SYNC_STAGES-1];

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= WAIT_IDLE;
            r_cnt   <= '0;
            r_prime <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_prime <= {r_prime[SYNC_STAGES-2:0], 1'b1};
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_latch    = 1'b0;
        w_abort    = 1'b0;
        case (r_state)
            WAIT_IDLE: begin
                if (w_primed && w_cs_s) begin
                    w_state_nx = IDLE;
                end
            end
            IDLE: begin
                if (w_wr_act) begin
                    w_state_nx = WR_SETTLE;
                    w_cnt_nx   = CNT_W'(1);
                end
            end
            WR_SETTLE: begin
                if (!w_wr_act) begin
                    w_abort    = 1'b1;
                    w_state_nx = IDLE;
                    w_cnt_nx   = '0;
                end else if (r_cnt == CNT_W'(SETTLE)) begin
                    w_latch    = 1'b1;
                    w_state_nx = COMMIT;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            COMMIT: begin
                w_state_nx = HOLD;
                w_cnt_nx   = '0;
            end
            HOLD: begin
                if (!w_wr_act) begin
                    w_state_nx = IDLE;
                end
            end
            default: begin
                w_state_nx = WAIT_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_xa_lat <= '0;
            r_xd_lat <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (w_latch) begin
                r_xa_lat <= i_Z_B_XA;
                r_xd_lat <= io_Z_B_XD;
            end
            if (w_commit_ok) begin
                r_wr_cnt <= r_wr_cnt + 16'd1;
            end
        end
    end

    assign w_wbank      = r_xa_lat[XA_W-1:RAM_AW];
    assign w_wbank_ok   = 32'(w_wbank) < BANK_N;
    assign w_commit     = (r_state == COMMIT);
    assign w_commit_ok  = w_commit & w_wbank_ok & ~i_wf_en;
    assign w_commit_err = w_commit & ~(w_wbank_ok & ~i_wf_en);

    assign w_rbank    = i_Z_B_XA[XA_W-1:RAM_AW];
    assign w_rbank_ok = 32'(w_rbank) < BANK_N;
    assign w_rd_pin   = i_rst & ~i_nZ_B_CS & i_nZ_B_WE;

    always_comb begin
        o_w_ram_ce  = '0;
        o_r_ram_ce  = '0;
        w_bank_dout = '0;
        for (int unsigned k = 0; k < BANK_N; k++) begin
            if (w_commit_ok && (w_wbank == BANK_W'(k))) begin
                o_w_ram_ce[k] = 1'b1;
            end
            if (w_rd_pin && !i_wf_en && (w_rbank == BANK_W'(k))) begin
                o_r_ram_ce[k] = 1'b1;
            end
            if (w_rbank == BANK_W'(k)) begin
                w_bank_dout = i_r_ram_dout[k*DATA_W +: DATA_W];
            end
        end
    end

    assign w_rd_data = i_wf_en ? i_wf_ram_dout : w_bank_dout;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_hold    <= '0;
            r_rd_prev <= 1'b0;
        end else begin
            r_rd_prev <= w_rd_act;
            if (w_rd_act) begin
                r_hold <= w_rd_data;
            end
        end
    end

    assign w_rd_err = w_rd_act & ~r_rd_prev & ~i_wf_en & ~w_rbank_ok;

    assign o_w_ram_we    = o_w_ram_ce;
    assign o_w_ram_addr  = r_xa_lat[RAM_AW-1:0];
    assign o_w_ram_din   = r_xd_lat;
    assign o_r_ram_addr  = i_Z_B_XA[RAM_AW-1:0];
    assign o_wf_ram_addr = i_Z_B_XA[RAM_AW-1:0];
    assign o_wf_ram_ce   = w_rd_pin & i_wf_en;
    assign o_wr_done     = w_commit_ok;
    assign o_wr_abort    = w_abort;
    assign o_bank_err    = w_commit_err | w_rd_err;
    assign o_wr_cnt      = r_wr_cnt;
    assign o_state       = r_state;

    assign io_Z_B_XD = w_rd_pin ? r_hold : 'z;

endmodule

// File: tb/tb_dsp_xintf_bank_bridge.sv
// Randomised bench for dsp_xintf_bank_bridge with BANK_N=3 so out-of-range banks exist.
// Expectations come from a transaction-level model of the bridge's write/read rules.
`timescale 1ns/1ps
module tb_dsp_xintf_bank_bridge;

    localparam int unsigned RAM_AW      = 9;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned BANK_N      = 3;
    localparam int unsigned XA_W        = 11;
    localparam int unsigned SETTLE      = 3;
    localparam int unsigned SYNC_STAGES = 2;

    localparam logic [31:0] ST_WAIT_IDLE = 32'd0;
    localparam logic [31:0] ST_IDLE      = 32'd1;
    localparam logic [31:0] ST_HOLD      = 32'd4;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic wf_en    = 1'b0;
    logic ncs      = 1'b1;
    logic nwe      = 1'b1;
    logic [XA_W-1:0]   xa       = '0;
    logic [DATA_W-1:0] tb_xd    = '0;
    logic              tb_xd_oe = 1'b0;
    wire  [DATA_W-1:0] xd_bus;

    logic [RAM_AW-1:0]        w_addr, r_addr, wf_addr;
    logic [BANK_N-1:0]        w_ce, w_we, r_ce;
    logic [DATA_W-1:0]        w_din;
    logic [BANK_N*DATA_W-1:0] r_dout = '0;
    logic                     wf_ce;
    logic [DATA_W-1:0]        wf_dout = '0;
    logic                     wr_done, wr_abort, bank_err;
    logic [15:0]              wr_cnt;
    logic [2:0]               state;

    assign xd_bus = tb_xd_oe ? tb_xd : 'z;
    pullup u_pu (xd_bus);

    always #5 clk = ~clk;

    dsp_xintf_bank_bridge #(
        .RAM_AW      (RAM_AW),
        .DATA_W      (DATA_W),
        .BANK_N      (BANK_N),
        .XA_W        (XA_W),
        .SETTLE      (SETTLE),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst_n),
        .i_wf_en       (wf_en),
        .i_nZ_B_CS     (ncs),
        .i_nZ_B_WE     (nwe),
        .i_Z_B_XA      (xa),
        .io_Z_B_XD     (xd_bus),
        .o_w_ram_addr  (w_addr),
        .o_w_ram_ce    (w_ce),
        .o_w_ram_we    (w_we),
        .o_w_ram_din   (w_din),
        .o_r_ram_addr  (r_addr),
        .o_r_ram_ce    (r_ce),
        .i_r_ram_dout  (r_dout),
        .o_wf_ram_addr (wf_addr),
        .o_wf_ram_ce   (wf_ce),
        .i_wf_ram_dout (wf_dout),
        .o_wr_done     (wr_done),
        .o_wr_abort    (wr_abort),
        .o_bank_err    (bank_err),
        .o_wr_cnt      (wr_cnt),
        .o_state       (state)
    );

    // Cumulative pulse/strobe counters; transactions compare before/after deltas.
    int unsigned        n_ce = 0, n_done = 0, n_abort = 0, n_err = 0, n_we_bad = 0;
    logic [BANK_N-1:0]  last_ce   = '0;
    logic [RAM_AW-1:0]  last_addr = '0;
    logic [DATA_W-1:0]  last_din  = '0;

    always @(negedge clk) begin
        if (w_ce != '0) begin
            n_ce++;
            last_ce   = w_ce;
            last_addr = w_addr;
            last_din  = w_din;
        end
        if (w_we != w_ce) n_we_bad++;
        if (wr_done)      n_done++;
        if (wr_abort)     n_abort++;
        if (bank_err)     n_err++;
    end

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [15:0] model_cnt = '0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rand16();
        return 16'($urandom_range(0, 32'hFFFE));
    endfunction

    // Strobe held low for len clock edges; commits only if it outlasts SETTLE.
    task automatic do_write(input logic [XA_W-1:0] a, input logic [15:0] d,
                            input int unsigned len, input logic wf_start, input logic wf_commit);
        int unsigned ce0, done0, ab0, err0, bank;
        logic e_ce, e_done, e_abort, e_err;
        ce0 = n_ce; done0 = n_done; ab0 = n_abort; err0 = n_err;
        bank = 32'(a) >> RAM_AW;
        wf_en = wf_start; xa = a; tb_xd = d; tb_xd_oe = 1'b1;
        ncs = 1'b0; nwe = 1'b0;
        if (len > 2) begin
            step(2);
            wf_en = wf_commit;
            step(len - 2);
        end else begin
            wf_en = wf_commit;
            step(len);
        end
        ncs = 1'b1; nwe = 1'b1;
        step(8);
        tb_xd_oe = 1'b0;
        e_ce = 1'b0; e_done = 1'b0; e_abort = 1'b0; e_err = 1'b0;
        if (len <= SETTLE) begin
            e_abort = 1'b1;
        end else if (bank < BANK_N && !wf_commit) begin
            e_ce = 1'b1; e_done = 1'b1;
            model_cnt = model_cnt + 16'd1;
        end else begin
            e_err = 1'b1;
        end
        chk_eq("wr_ce_cycles", n_ce - ce0, 32'(e_ce));
        chk_eq("wr_done",      n_done - done0, 32'(e_done));
        chk_eq("wr_abort",     n_abort - ab0, 32'(e_abort));
        chk_eq("wr_bank_err",  n_err - err0, 32'(e_err));
        chk_eq("wr_cnt",       32'(wr_cnt), 32'(model_cnt));
        if (e_ce) begin
            chk_eq("wr_ce_onehot", 32'(last_ce), 32'd1 << bank);
            chk_eq("wr_addr",      32'(last_addr), 32'(a[RAM_AW-1:0]));
            chk_eq("wr_din",       32'(last_din), 32'(d));
        end
    endtask

    task automatic do_read(input logic [XA_W-1:0] a, input logic wf);
        int unsigned err0, bank;
        logic [15:0] dv [BANK_N];
        logic [15:0] exp_data;
        err0 = n_err;
        bank = 32'(a) >> RAM_AW;
        for (int k = 0; k < int'(BANK_N); k++) begin
            dv[k] = rand16();
            r_dout[k*DATA_W +: DATA_W] = dv[k];
        end
        wf_dout = rand16();
        wf_en = wf; xa = a; ncs = 1'b0; nwe = 1'b1;
        #1;
        chk_eq("rd_ce",   32'(r_ce), (wf || bank >= BANK_N) ? 32'd0 : (32'd1 << bank));
        chk_eq("rd_addr", 32'(r_addr), 32'(a[RAM_AW-1:0]));
        chk_eq("wf_ce",   32'(wf_ce), 32'(wf));
        if (wf) chk_eq("wf_addr", 32'(wf_addr), 32'(a[RAM_AW-1:0]));
        step(SYNC_STAGES + 2);
        if (wf)                exp_data = wf_dout;
        else if (bank < BANK_N) exp_data = dv[bank];
        else                    exp_data = 16'h0000;
        chk_eq("rd_data", 32'(xd_bus), 32'(exp_data));
        ncs = 1'b1;
        #1;
        chk_eq("rd_release_z", 32'(xd_bus), 32'hFFFF);
        step(4);
        chk_eq("rd_bank_err", n_err - err0, 32'(!wf && bank >= BANK_N));
    endtask

    initial begin
        int unsigned ce0, done0;
        logic seen_hold;
        logic [XA_W-1:0] ra;

        rst_n = 1'b0;
        step(3);
        chk_eq("rst_state",   32'(state), ST_WAIT_IDLE);
        chk_eq("rst_wr_cnt",  32'(wr_cnt), 32'd0);
        chk_eq("rst_w_ce",    32'(w_ce), 32'd0);
        chk_eq("rst_w_addr",  32'(w_addr), 32'd0);
        chk_eq("rst_w_din",   32'(w_din), 32'd0);
        chk_eq("rst_bus_z",   32'(xd_bus), 32'hFFFF);
        chk_eq("rst_pulses",  32'({wr_done, wr_abort, bank_err}), 32'd0);
        rst_n = 1'b1;
        step(6);
        chk_eq("boot_idle", 32'(state), ST_IDLE);

        do_write(11'h205, 16'hBEEF, 10, 1'b0, 1'b0);
        do_write(11'h07A, 16'h1357, 2, 1'b0, 1'b0);
        do_write(11'h011, 16'h2222, SETTLE, 1'b0, 1'b0);
        do_write(11'h012, 16'h3333, SETTLE + 1, 1'b0, 1'b0);
        do_read(11'h310, 1'b0);
        do_read(11'h0AB, 1'b1);
        do_write(11'h044, 16'h0A0A, 8, 1'b1, 1'b1);
        do_write(11'h600, 16'h5555, 8, 1'b0, 1'b0);
        do_read(11'h600, 1'b0);
        do_write(11'h123, 16'hC0DE, 9, 1'b1, 1'b0);
        do_write(11'h124, 16'hDEAD, 9, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            ra = XA_W'($urandom);
            if ($urandom_range(0, 1) == 0)
                do_write(ra, rand16(), $urandom_range(1, 8),
                         1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
            else
                do_read(ra, 1'($urandom_range(0, 2) == 0));
        end
        chk_eq("we_equals_ce", n_we_bad, 32'd0);

        // Reset in the middle of a held write strobe.
        wf_en = 1'b0; xa = 11'h101; tb_xd = 16'h7777; tb_xd_oe = 1'b1;
        ncs = 1'b0; nwe = 1'b0;
        seen_hold = 1'b0;
        for (int i = 0; i < 30 && !seen_hold; i++) begin
            step(1);
            if (32'(state) == ST_HOLD) seen_hold = 1'b1;
        end
        chk_eq("hold_reached", 32'(seen_hold), 32'd1);
        model_cnt = model_cnt + 16'd1;
        rst_n = 1'b0;
        step(3);
        chk_eq("midrst_state",  32'(state), ST_WAIT_IDLE);
        chk_eq("midrst_wr_cnt", 32'(wr_cnt), 32'd0);
        chk_eq("midrst_w_ce",   32'(w_ce), 32'd0);
        chk_eq("midrst_w_addr", 32'(w_addr), 32'd0);
        model_cnt = '0;
        ce0 = n_ce; done0 = n_done;
        rst_n = 1'b1;
        step(12);
        chk_eq("postrst_no_commit", n_ce - ce0, 32'd0);
        chk_eq("postrst_no_done",   n_done - done0, 32'd0);
        chk_eq("postrst_wait",      32'(state), ST_WAIT_IDLE);
        ncs = 1'b1; nwe = 1'b1;
        step(6);
        tb_xd_oe = 1'b0;
        chk_eq("postrst_idle", 32'(state), ST_IDLE);
        do_write(11'h0C3, 16'h4242, 6, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
